// File: rtl/game_pkg.sv
// Shared game definitions: Goomba life-cycle states, tile codes and playfield geometry.
// Imported by the Goomba stomp resolver and the coin/block collision logic.
package game_pkg;

  localparam int CHARACTER_WIDTH = 42;
  localparam int SCREEN_WIDTH    = 640;
  localparam int SCREEN_HEIGHT   = 480;
  localparam int BLOCK_WIDTH     = 42;

  typedef enum logic [2:0] {
    ARM,
    ALIVE,
    SQUISHED,
    DEAD,
    LOSE
  } goomba_state_e;

  typedef enum logic [1:0] {
    BDR,
    SKY,
    BLK,
    GND
  } tile_e;

endpackage

// File: rtl/goomba_stomp_resolver_if.sv
// Mario/Goomba contact bus: positions in, Goomba status flags out.
// The score signal exists only when GOOMBA_SCORE_EN is defined.
interface goomba_stomp_resolver_if;

  logic signed [31:0] mario_x;
  logic signed [31:0] mario_y;
  logic signed [31:0] goomba_x;
  logic signed [31:0] goomba_y;
  logic               goomba_alive;
  logic               goomba_squished;
  logic               bounce;
  logic               lose;
`ifdef GOOMBA_SCORE_EN
  logic        [31:0] score;

  modport master (
    output mario_x, mario_y, goomba_x, goomba_y,
    input  goomba_alive, goomba_squished, bounce, lose, score
  );

  modport slave (
    input  mario_x, mario_y, goomba_x, goomba_y,
    output goomba_alive, goomba_squished, bounce, lose, score
  );
`else
  modport master (
    output mario_x, mario_y, goomba_x, goomba_y,
    input  goomba_alive, goomba_squished, bounce, lose
  );

  modport slave (
    input  mario_x, mario_y, goomba_x, goomba_y,
    output goomba_alive, goomba_squished, bounce, lose
  );
`endif

endinterface

// File: rtl/aabb_overlap.sv
// One-axis box overlap: [a, a+WIDTH] touches [b, b+WIDTH]; edges touching count as overlap.
// Purely combinational, 32-bit signed, wrapping arithmetic.
module aabb_overlap #(
  parameter int WIDTH = 42
) (
  input  logic signed [31:0] a_pos,
  input  logic signed [31:0] b_pos,
  output logic               overlap
);

  localparam logic signed [31:0] WIDTH_S = WIDTH;

  logic signed [31:0] a_end;
  logic signed [31:0] b_end;

  assign a_end   = a_pos + WIDTH_S;
  assign b_end   = b_pos + WIDTH_S;
  assign overlap = (a_end >= b_pos) && (a_pos <= b_end);

endmodule

// File: rtl/goomba_stomp_resolver.sv
// Classifies Mario/Goomba contact as stomp or side hit and runs the Goomba life cycle.
// Optional stomp score register is built when GOOMBA_SCORE_EN is defined.
module goomba_stomp_resolver #(
  parameter int          CHARACTER_WIDTH = game_pkg::CHARACTER_WIDTH,
  parameter int          STOMP_MARGIN    = 8,
  parameter int          SQUISH_TICKS    = 30,
  parameter logic [31:0] SCORE_PER_STOMP = 32'd100
) (
  input  logic             movement_clock,
  input  logic             reset,
  goomba_stomp_resolver_if.slave bus
);

  import game_pkg::*;

  localparam int                 CNT_W     = (SQUISH_TICKS > 1) ? $clog2(SQUISH_TICKS) : 1;
  localparam logic [CNT_W-1:0]   LAST_TICK = CNT_W'(SQUISH_TICKS - 1);
  localparam logic signed [31:0] WIDTH_S   = CHARACTER_WIDTH;
  localparam logic signed [31:0] MARGIN_S  = STOMP_MARGIN;

  goomba_state_e      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic signed [31:0] prev_mario_y_q;
  logic               alive_q, alive_d;
  logic               squished_q, squished_d;
  logic               bounce_q, bounce_d;
  logic               lose_q, lose_d;

  logic               overlap_x;
  logic               overlap_y;
  logic               contact;
  logic               falling;
  logic               stomp_zone;
  logic signed [31:0] mario_bottom;

  aabb_overlap #(.WIDTH(CHARACTER_WIDTH)) u_overlap_x (
    .a_pos   (bus.mario_x),
    .b_pos   (bus.goomba_x),
    .overlap (overlap_x)
  );

  aabb_overlap #(.WIDTH(CHARACTER_WIDTH)) u_overlap_y (
    .a_pos   (bus.mario_y),
    .b_pos   (bus.goomba_y),
    .overlap (overlap_y)
  );

  assign contact      = overlap_x && overlap_y;
  assign falling      = bus.mario_y > prev_mario_y_q;
  assign mario_bottom = bus.mario_y + WIDTH_S;
  assign stomp_zone   = (mario_bottom >= bus.goomba_y) &&
                        (mario_bottom <  bus.goomba_y + MARGIN_S);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARM:   state_d = ALIVE;
      ALIVE: begin
        // Stomp is tested first so it wins when both stomp and side-hit conditions hold.
        if (contact && falling && stomp_zone) begin
          state_d = SQUISHED;
          cnt_d   = '0;
        end else if (contact) begin
          state_d = LOSE;
        end
      end
      SQUISHED: begin
        if (cnt_q == LAST_TICK) state_d = DEAD;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      DEAD, LOSE: ;
      default: state_d = ARM;
    endcase

    // Outputs are decoded from the next state and registered, so they track state_q exactly.
    alive_d    = (state_d == ALIVE) || (state_d == LOSE);
    squished_d = (state_d == SQUISHED);
    bounce_d   = (state_q == ALIVE) && (state_d == SQUISHED);
    lose_d     = (state_d == LOSE);
  end

`ifdef GOOMBA_SCORE_EN
  logic [31:0] score_q, score_d;

  always_comb begin
    score_d = bounce_d ? (score_q + SCORE_PER_STOMP) : score_q;
  end

  assign bus.score = score_q;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge movement_clock) begin
    prev_mario_y_q <= bus.mario_y;
    if (reset) begin
      state_q    <= ARM;
      cnt_q      <= '0;
      alive_q    <= 1'b0;
      squished_q <= 1'b0;
      bounce_q   <= 1'b0;
      lose_q     <= 1'b0;
`ifdef GOOMBA_SCORE_EN
      score_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alive_q    <= alive_d;
      squished_q <= squished_d;
      bounce_q   <= bounce_d;
      lose_q     <= lose_d;
`ifdef GOOMBA_SCORE_EN
      score_q    <= score_d;
`endif
    end
  end

  assign bus.goomba_alive    = alive_q;
  assign bus.goomba_squished = squished_q;
  assign bus.bounce          = bounce_q;
  assign bus.lose            = lose_q;

endmodule

// File: tb/tb_goomba_stomp_resolver.sv
// Directed bench for goomba_stomp_resolver: reset, stomp, side hit, rising/level/band-edge hits,
// reset mid-squish and mid-lose; score checks are active when GOOMBA_SCORE_EN is defined.
module tb_goomba_stomp_resolver;

  logic movement_clock = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  goomba_stomp_resolver_if bus ();

  goomba_stomp_resolver dut (
    .movement_clock (movement_clock),
    .reset          (reset),
    .bus            (bus)
  );

  always #5 movement_clock = ~movement_clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge movement_clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic alive, input logic squished,
                             input logic bounce, input logic lose);
    check({tag, ".alive"},    32'(bus.goomba_alive),    32'(alive));
    check({tag, ".squished"}, 32'(bus.goomba_squished), 32'(squished));
    check({tag, ".bounce"},   32'(bus.bounce),          32'(bounce));
    check({tag, ".lose"},     32'(bus.lose),            32'(lose));
  endtask

  task automatic check_score(input string tag, input logic [31:0] exp);
`ifdef GOOMBA_SCORE_EN
    check({tag, ".score"}, bus.score, exp);
`else
    if (tag.len() > 0 && exp == 32'hFFFF_FFFF) $display("score %s not built", tag);
`endif
  endtask

  task automatic set_pos(input int mx, input int my, input int gx, input int gy);
    bus.mario_x  = mx;
    bus.mario_y  = my;
    bus.goomba_x = gx;
    bus.goomba_y = gy;
  endtask

  initial begin
    // 1. Reset held two ticks, ARM for one tick, then ALIVE.
    reset = 1'b1;
    set_pos(0, 0, 300, 398);
    tick();
    tick();
    check_flags("reset", 0, 0, 0, 0);
    check_score("reset", 0);
    reset = 1'b0;
    tick();
    check_flags("arm_exit", 1, 0, 0, 0);

    // 2. Stomp: Mario falls 350 -> 356, bottom edge lands exactly on goomba_y.
    set_pos(290, 350, 300, 398);
    tick();
    check_flags("approach", 1, 0, 0, 0);
    bus.mario_y = 356;
    tick();
    check_flags("stomp", 0, 1, 1, 0);
    check_score("stomp", 100);
    tick();
    check_flags("squish1", 0, 1, 0, 0);
    repeat (28) tick();
    check_flags("squish29", 0, 1, 0, 0);
    tick();
    check_flags("dead", 0, 0, 0, 0);
    repeat (5) tick();
    check_flags("dead_hold", 0, 0, 0, 0);
    check_score("dead_hold", 100);

    // 3. Side hit with Mario level at (262,398).
    set_pos(0, 398, 300, 398);
    reset = 1'b1;
    tick();
    check_flags("rst_dead", 0, 0, 0, 0);
    check_score("rst_dead", 0);
    reset = 1'b0;
    tick();
    check_flags("alive2", 1, 0, 0, 0);
    bus.mario_x = 262;
    tick();
    check_flags("side_hit", 1, 0, 0, 1);
    bus.mario_x = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("lose_hold", 32'(bus.lose), 32'd1);
    end
    check_flags("lose_end", 1, 0, 0, 1);

    // Reset mid-LOSE, then 4. rising 358 -> 352 through the band of a Goomba at y=392.
    set_pos(0, 358, 300, 392);
    reset = 1'b1;
    tick();
    check_flags("rst_lose", 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    check_flags("alive3", 1, 0, 0, 0);
    set_pos(290, 352, 300, 392);
    tick();
    check_flags("rising", 1, 0, 0, 1);

    // Level inside the stomp band is a side hit.
    set_pos(0, 356, 300, 398);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    bus.mario_x = 290;
    tick();
    check_flags("level", 1, 0, 0, 1);

    // Falling with bottom edge at goomba_y+STOMP_MARGIN is outside the band.
    set_pos(0, 356, 300, 398);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    set_pos(290, 364, 300, 398);
    tick();
    check_flags("band_edge", 1, 0, 0, 1);

    // 5. Stomp at the last row of the band, then reset at SQUISHED tick 10.
    set_pos(0, 356, 300, 398);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    set_pos(290, 363, 300, 398);
    tick();
    check_flags("stomp_edge", 0, 1, 1, 0);
    check_score("stomp_edge", 100);
    repeat (10) tick();
    check_flags("squish10", 0, 1, 0, 0);
    set_pos(0, 350, 300, 398);
    reset = 1'b1;
    tick();
    check_flags("rst_squish", 0, 0, 0, 0);
    check_score("rst_squish", 0);
    reset = 1'b0;
    tick();
    check_flags("alive4", 1, 0, 0, 0);

    // Second full stomp: counter must restart from 0 after the mid-squish reset.
    bus.mario_x = 290;
    tick();
    bus.mario_y = 356;
    tick();
    check_flags("stomp2", 0, 1, 1, 0);
    check_score("stomp2", 100);
    repeat (29) tick();
    check_flags("squish29b", 0, 1, 0, 0);
    tick();
    check_flags("dead2", 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
